// File: rtl/phase_sequencer.sv
// phase_sequencer: single-clock controller for the multicycle core. It issues one-cycle
// phase enables, stalls on exBusy/memWait, and provides run/step control and perf counters.
module phase_sequencer #(
  parameter int unsigned MA_TIMEOUT = 1023,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             rwmem,
  input  logic             memWait,
  input  logic             exBusy,
  output logic             en_ft,
  output logic             en_dc,
  output logic             en_ex,
  output logic             en_ma,
  output logic             en_wb,
  output logic [2:0]       phase,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FT   = 3'd1,
    DC   = 3'd2,
    EX   = 3'd3,
    EXW  = 3'd4,
    MA   = 3'd5,
    MAW  = 3'd6,
    WB   = 3'd7
  } state_t;

  // A zero MA_TIMEOUT disables the fault; the counter then only needs to exist.
  localparam bit                TIMEOUT_EN = (MA_TIMEOUT != 0);
  localparam int unsigned       WAIT_W     = TIMEOUT_EN ? $clog2(MA_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_EN ? MA_TIMEOUT - 1 : 0);

  state_t            state_q, state_d;
  logic              step_pend_q, step_pend_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              timeout_hit;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    step_pend_d = step_pend_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_timeout) begin
          if (run_i) begin
            state_d = FT;
          end else if (step_i) begin
            state_d     = FT;
            step_pend_d = 1'b1;
          end
        end
      end
      FT:  state_d = DC;
      DC:  state_d = EX;
      EX:  state_d = EXW;
      EXW: begin
        if (!exBusy) state_d = rwmem ? MA : WB;
      end
      MA:  state_d = MAW;
      MAW: begin
        if (!memWait) begin
          state_d = WB;
        end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
          // This cycle is the MA_TIMEOUT-th stalled one: abandon the instruction without WB.
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WB: begin
        step_pend_d = 1'b0;
        state_d     = (step_pend_q || !run_i) ? IDLE : FT;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      step_pend_q <= 1'b0;
      wait_cnt_q  <= '0;
      mem_timeout <= 1'b0;
      retired     <= '0;
      cycles      <= '0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      if (state_q == MA) begin
        wait_cnt_q <= '0;
      end else if ((state_q == MAW) && memWait) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (timeout_hit)       mem_timeout <= 1'b1;
      if (state_q == WB)     retired     <= retired + 1'b1;
      if (state_q != IDLE)   cycles      <= cycles + 1'b1;
    end
  end

  // Moore outputs: decoded only from the state register.
  assign en_ft  = (state_q == FT);
  assign en_dc  = (state_q == DC);
  assign en_ex  = (state_q == EX);
  assign en_ma  = (state_q == MA);
  assign en_wb  = (state_q == WB);
  assign phase  = state_q;
  assign halted = (state_q == IDLE);

endmodule
